// File: rtl/mips_pkg.sv
// mips_pkg: shared MEM-stage definitions.
// Contents: access-size encodings (SZ_NONE/BYTE/HALF/WORD), the MEM FSM state
// type, the captured-request record held while an access is outstanding, and
// helpers for byte-enable generation and store-lane replication.
package mips_pkg;
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic {IDLE, WAIT} mem_state_t;

  typedef struct packed {
    logic        regWrite;
    logic        memToReg;
    logic        jump;
    logic        we;
    logic        sgn;
    logic [1:0]  size;
    logic [1:0]  lane;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] aluOut;
    logic [4:0]  writeReg;
  } mem_req_t;

  function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] lane);
    return size == SZ_WORD ? 4'b1111 :
           size == SZ_HALF ? 4'b0011 << lane :
           size == SZ_BYTE ? 4'b0001 << lane : 4'b0000;
  endfunction

  function automatic logic [31:0] laneData(input logic [1:0] size, input logic [31:0] d);
    return size == SZ_BYTE ? {4{d[7:0]}} :
           size == SZ_HALF ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/memory_stage_if.sv
// memory_stage_if: data-memory request/ready bus between the MEM stage and memory.
// master (MEM stage): drives dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata;
//                     receives dmem_ready, dmem_rdata.
// slave  (memory)   : the mirror image.
interface memory_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master(output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                 input dmem_ready, dmem_rdata);
  modport slave(input dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                output dmem_ready, dmem_rdata);
endinterface

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half lane of a read word and extends it.
// Ports: rdata (read word), a (byte lane), size (SZ_* encoding), sgn (1 = sign
// extend) -> result (32-bit register value). Word/none sizes pass rdata through.
import mips_pkg::*;

module load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata[{a, 3'b000} +: 8];
  assign h = a[1] ? rdata[31:16] : rdata[15:0];
  assign result = size == SZ_BYTE ? {{24{sgn & b[7]}}, b} :
                  size == SZ_HALF ? {{16{sgn & h[15]}}, h} : rdata;
endmodule

// File: rtl/memory_stage.sv
// memory_stage: MIPS MEM stage - data-memory handshake, load alignment, MEM/WB register.
// Ports: clk, rst (async, active-low); M-side control/data from execute;
// dmem (memory_stage_if.master) data-memory bus; StallM to the hazard unit;
// W-side MEM/WB outputs plus one-cycle BusErrW / AddrErrW pulses.
// Parameter TIMEOUT_CYCLES: WAIT cycles without ready before a bus error (0 = never).
// Build option MEM_ALIGN_CHECK_EN: reject misaligned half/word accesses with
// AddrErrW instead of silently forcing the low address bits.
import mips_pkg::*;

module memory_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic                  MemToRegM,
  input  logic                  jumpM,
  input  logic [1:0]            MemWriteM,
  input  logic [1:0]            LoadSizeM,
  input  logic                  LoadSgnM,
  input  logic [31:0]           ALUOutM,
  input  logic [31:0]           WriteDataM,
  input  logic [4:0]            WriteRegM,
  memory_stage_if.master        dmem,
  output logic                  StallM,
  output logic                  RegWriteW,
  output logic                  MemToRegW,
  output logic                  jumpW,
  output logic [31:0]           ReadDataW,
  output logic [31:0]           ALUOutW,
  output logic [4:0]            WriteRegW,
  output logic                  BusErrW,
  output logic                  AddrErrW
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

  mem_state_t  state, nextState;
  logic [CW-1:0] cnt;
  mem_req_t    cur, held, src;
  logic        isStore, isAccess, misaligned, timeout, addrErr, req, done, bubble;
  logic [1:0]  size, lane;
  logic [31:0] loadData;

  // A store wins over a load when both are flagged.
  assign isStore  = MemWriteM != SZ_NONE;
  assign isAccess = isStore | MemToRegM;
  assign size     = isStore ? MemWriteM : LoadSizeM;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = isAccess && ((size == SZ_HALF && ALUOutM[0]) ||
                                   (size == SZ_WORD && ALUOutM[1:0] != 2'b00));
  assign lane = ALUOutM[1:0];
`else
  // No checking: drop the address bits a misaligned access cannot use.
  assign misaligned = 1'b0;
  assign lane = size == SZ_WORD ? 2'b00 : size == SZ_HALF ? {ALUOutM[1], 1'b0} : ALUOutM[1:0];
`endif

  assign cur = '{regWrite: RegWriteM, memToReg: MemToRegM, jump: jumpM, we: isStore,
                 sgn: LoadSgnM, size: size, lane: lane, be: byteEnable(size, lane),
                 addr: {ALUOutM[31:2], 2'b00}, wdata: laneData(size, WriteDataM),
                 aluOut: ALUOutM, writeReg: WriteRegM};

  // While waiting, the bus and the instruction come from the captured copy so
  // the (frozen or changing) M inputs cannot disturb the access.
  assign src     = state == WAIT ? held : cur;
  assign timeout = state == WAIT && TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES);
  assign addrErr = state == IDLE && misaligned;

  always_comb begin
    req       = state == IDLE ? isAccess && !misaligned : !timeout;
    done      = !req || dmem.dmem_ready;
    nextState = done ? IDLE : WAIT;
    StallM    = !done;
    bubble    = !done || timeout || addrErr;
  end

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = src.we;
  assign dmem.dmem_addr  = src.addr;
  assign dmem.dmem_be    = src.be;
  assign dmem.dmem_wdata = src.wdata;

  load_align u_align (
    .rdata (dmem.dmem_rdata),
    .a     (src.lane),
    .size  (src.size),
    .sgn   (src.sgn),
    .result(loadData)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      held      <= '0;
      RegWriteW <= 1'b0;
      MemToRegW <= 1'b0;
      jumpW     <= 1'b0;
      ReadDataW <= '0;
      ALUOutW   <= '0;
      WriteRegW <= '0;
      BusErrW   <= 1'b0;
      AddrErrW  <= 1'b0;
    end else begin
      cnt       <= state == WAIT ? cnt + 1'b1 : '0;
      if (state == IDLE) held <= cur;
      RegWriteW <= src.regWrite && !bubble;
      MemToRegW <= src.memToReg && !bubble;
      jumpW     <= src.jump && !bubble;
      ReadDataW <= loadData;
      ALUOutW   <= src.aluOut;
      WriteRegW <= src.writeReg;
      BusErrW   <= timeout;
      AddrErrW  <= addrErr;
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: scoreboard bench for memory_stage (TIMEOUT_CYCLES = 4).
import mips_pkg::*;

module tb_memory_stage;
  typedef struct packed {
    logic        regWrite, memToReg, jump;
    logic [31:0] readData, aluOut;
    logic [4:0]  writeReg;
    logic        busErr, addrErr;
  } wb_t;
  typedef struct { wb_t v; wb_t m; } sb_t;

  localparam wb_t M_ALL  = '1;
  localparam wb_t M_NORD = {3'b111, 32'h0, 32'hFFFF_FFFF, 5'h1F, 2'b11};
  localparam wb_t M_CTRL = {3'b111, 32'h0, 32'h0, 5'h0, 2'b11};

  logic clk = 1'b0, rst = 1'b1;
  logic RegWriteM, MemToRegM, jumpM, LoadSgnM;
  logic [1:0] MemWriteM, LoadSizeM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0] WriteRegM;
  logic StallM, RegWriteW, MemToRegW, jumpW, BusErrW, AddrErrW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [4:0] WriteRegW;
  wb_t obs;
  sb_t q[$];
  sb_t e;
  int total = 0, bad = 0;

  memory_stage_if dmem();

  memory_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .jumpM(jumpM),
    .MemWriteM(MemWriteM), .LoadSizeM(LoadSizeM), .LoadSgnM(LoadSgnM), .ALUOutM(ALUOutM),
    .WriteDataM(WriteDataM), .WriteRegM(WriteRegM), .dmem(dmem), .StallM(StallM),
    .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .jumpW(jumpW), .ReadDataW(ReadDataW),
    .ALUOutW(ALUOutW), .WriteRegW(WriteRegW), .BusErrW(BusErrW), .AddrErrW(AddrErrW)
  );

  assign obs = {RegWriteW, MemToRegW, jumpW, ReadDataW, ALUOutW, WriteRegW, BusErrW, AddrErrW};

  always #5 clk = ~clk;

  function automatic wb_t mk(input logic rw, mtr, j, input logic [31:0] rd, alu,
                             input logic [4:0] wr, input logic be, ae);
    return '{regWrite: rw, memToReg: mtr, jump: j, readData: rd, aluOut: alu,
             writeReg: wr, busErr: be, addrErr: ae};
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] d, input logic [1:0] a,
                                             input logic [1:0] sz, input logic sg);
    logic [31:0] s;
    s = d >> (8 * int'(a));
    if (sz == SZ_BYTE) return sg ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
    if (sz == SZ_HALF) return sg ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
    return d;
  endfunction

  task automatic set_m(input logic rw, mtr, j, input logic [1:0] mw, ls, input logic sg,
                       input logic [31:0] alu, wd, input logic [4:0] wr);
    RegWriteM = rw; MemToRegM = mtr; jumpM = j; MemWriteM = mw; LoadSizeM = ls;
    LoadSgnM = sg; ALUOutM = alu; WriteDataM = wd; WriteRegM = wr;
  endtask

  task automatic nop();
    set_m(0, 0, 0, SZ_NONE, SZ_NONE, 0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    total += 3;
    if (obs !== '0) begin bad++; $display("FAIL reset_w: got %h want 0", obs); end
    if (dmem.dmem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", dmem.dmem_req); end
    if (StallM !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", StallM); end
    rst = 1'b1;
  endtask

  task automatic test_zero_wait_load();
    @(negedge clk);
    set_m(1, 1, 0, SZ_NONE, SZ_WORD, 0, 32'h100, 32'h0, 5'd3);
    dmem.dmem_ready = 1'b1; dmem.dmem_rdata = 32'hDEADBEEF;
    q.push_back(sb_t'{mk(1, 1, 0, 32'hDEADBEEF, 32'h100, 5'd3, 0, 0), M_ALL});
    #1;
    total += 2;
    if ({dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_be} !== {1'b1, 1'b0, 32'h100, 4'hF}) begin
      bad++; $display("FAIL lw_bus: got req=%b we=%b addr=%h be=%b want 1 0 00000100 1111",
                      dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_be);
    end
    if (StallM !== 1'b0) begin bad++; $display("FAIL lw_stall: got %b want 0", StallM); end
    @(posedge clk); #1;
    nop(); dmem.dmem_ready = 1'b0;
    e = q.pop_front(); total++;
    if ((obs & e.m) !== (e.v & e.m)) begin bad++; $display("FAIL lw_w: got %h want %h", obs & e.m, e.v & e.m); end
  endtask

  task automatic test_wait_store();
    int stalls = 0;
    @(negedge clk);
    set_m(0, 0, 0, SZ_BYTE, SZ_NONE, 0, 32'h103, 32'h5A, 5'd0);
    dmem.dmem_ready = 1'b0;
    q.push_back(sb_t'{mk(0, 0, 0, 32'h0, 32'h103, 5'd0, 0, 0), M_NORD});
    for (int k = 0; k < 4; k++) begin
      // Unrelated instruction appears on M while waiting; it must be ignored.
      if (k > 0) begin @(negedge clk); set_m(1, 0, 1, SZ_NONE, SZ_NONE, 0, 32'hBAD0, 32'hFFFF, 5'd9); end
      dmem.dmem_ready = (k == 3);
      #1;
      total++;
      if ({dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_be, dmem.dmem_wdata} !==
          {1'b1, 1'b1, 32'h100, 4'b1000, 32'h5A5A5A5A}) begin
        bad++; $display("FAIL sb_bus[%0d]: got req=%b we=%b addr=%h be=%b wdata=%h want 1 1 00000100 1000 5a5a5a5a",
                        k, dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_be, dmem.dmem_wdata);
      end
      stalls += int'(StallM);
      @(posedge clk); #1;
      if (k < 3) begin
        total++;
        if ({RegWriteW, MemToRegW, jumpW} !== 3'b000) begin
          bad++; $display("FAIL sb_bubble[%0d]: got %b want 000", k, {RegWriteW, MemToRegW, jumpW});
        end
      end
    end
    nop(); dmem.dmem_ready = 1'b0;
    total++;
    if (stalls != 3) begin bad++; $display("FAIL sb_stall_cycles: got %0d want 3", stalls); end
    e = q.pop_front(); total++;
    if ((obs & e.m) !== (e.v & e.m)) begin bad++; $display("FAIL sb_w: got %h want %h", obs & e.m, e.v & e.m); end
  endtask

  task automatic test_half_loads();
    logic [31:0] want [2];
    want[0] = 32'hFFFF8001; want[1] = 32'h00008001;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_m(1, 1, 0, SZ_NONE, SZ_HALF, k == 0, 32'h102, 32'h0, 5'(4 + k));
      dmem.dmem_ready = 1'b1; dmem.dmem_rdata = 32'h8001_0000;
      q.push_back(sb_t'{mk(1, 1, 0, want[k], 32'h102, 5'(4 + k), 0, 0), M_ALL});
      #1;
      total++;
      if ({dmem.dmem_be, StallM} !== {4'b1100, 1'b0}) begin
        bad++; $display("FAIL lh_bus[%0d]: got be=%b stall=%b want 1100 0", k, dmem.dmem_be, StallM);
      end
      @(posedge clk); #1;
      e = q.pop_front(); total++;
      if ((obs & e.m) !== (e.v & e.m)) begin bad++; $display("FAIL lh_w[%0d]: got %h want %h", k, obs & e.m, e.v & e.m); end
    end
    nop(); dmem.dmem_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int reqs = 0, n = 0;
    @(negedge clk);
    set_m(1, 1, 0, SZ_NONE, SZ_WORD, 0, 32'h200, 32'h0, 5'd5);
    dmem.dmem_ready = 1'b0;
    q.push_back(sb_t'{mk(0, 0, 0, 32'h0, 32'h0, 5'd0, 1, 0), M_CTRL});
    #1;
    while (StallM === 1'b1 && n < 20) begin
      reqs += int'(dmem.dmem_req);
      n++;
      @(posedge clk); #1;
      nop();
    end
    total++;
    if (reqs != 5 || dmem.dmem_req !== 1'b0) begin
      bad++; $display("FAIL to_req: got %0d req cycles, req now %b; want 5 then 0", reqs, dmem.dmem_req);
    end
    @(posedge clk); #1;
    e = q.pop_front(); total++;
    if ((obs & e.m) !== (e.v & e.m)) begin bad++; $display("FAIL to_w: got %h want %h", obs & e.m, e.v & e.m); end
    @(posedge clk); #1;
    total++;
    if (BusErrW !== 1'b0) begin bad++; $display("FAIL to_pulse: got %b want 0", BusErrW); end
  endtask

  task automatic test_align();
    @(negedge clk);
    set_m(1, 1, 0, SZ_NONE, SZ_WORD, 0, 32'h102, 32'h0, 5'd6);
    dmem.dmem_ready = 1'b1; dmem.dmem_rdata = 32'h11223344;
`ifdef MEM_ALIGN_CHECK_EN
    q.push_back(sb_t'{mk(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 1), M_CTRL});
    #1;
    total++;
    if ({dmem.dmem_req, StallM} !== 2'b00) begin
      bad++; $display("FAIL al_req: got req=%b stall=%b want 0 0", dmem.dmem_req, StallM);
    end
`else
    q.push_back(sb_t'{mk(1, 1, 0, 32'h11223344, 32'h102, 5'd6, 0, 0), M_ALL});
    #1;
    total++;
    if ({dmem.dmem_req, dmem.dmem_addr, dmem.dmem_be} !== {1'b1, 32'h100, 4'hF}) begin
      bad++; $display("FAIL al_bus: got req=%b addr=%h be=%b want 1 00000100 1111",
                      dmem.dmem_req, dmem.dmem_addr, dmem.dmem_be);
    end
`endif
    @(posedge clk); #1;
    nop(); dmem.dmem_ready = 1'b0;
    e = q.pop_front(); total++;
    if ((obs & e.m) !== (e.v & e.m)) begin bad++; $display("FAIL al_w: got %h want %h", obs & e.m, e.v & e.m); end
    @(posedge clk); #1;
    total++;
    if (AddrErrW !== 1'b0) begin bad++; $display("FAIL al_pulse: got %b want 0", AddrErrW); end
  endtask

  task automatic test_alu_pass();
    @(negedge clk);
    set_m(1, 0, 1, SZ_NONE, SZ_NONE, 0, 32'h12345678, 32'h0, 5'd7);
    q.push_back(sb_t'{mk(1, 0, 1, 32'h0, 32'h12345678, 5'd7, 0, 0), M_NORD});
    #1;
    total++;
    if ({dmem.dmem_req, StallM} !== 2'b00) begin
      bad++; $display("FAIL alu_req: got req=%b stall=%b want 0 0", dmem.dmem_req, StallM);
    end
    @(posedge clk); #1;
    nop();
    e = q.pop_front(); total++;
    if ((obs & e.m) !== (e.v & e.m)) begin bad++; $display("FAIL alu_w: got %h want %h", obs & e.m, e.v & e.m); end
  endtask

  task automatic test_reset_wait();
    @(negedge clk);
    set_m(1, 1, 0, SZ_NONE, SZ_WORD, 0, 32'h300, 32'h0, 5'd8);
    dmem.dmem_ready = 1'b0;
    @(posedge clk); #1;
    nop();
    #2 rst = 1'b0;
    #1;
    total++;
    if ({dmem.dmem_req, StallM} !== 2'b00 || obs !== '0) begin
      bad++; $display("FAIL rst_wait: got req=%b stall=%b w=%h want 0 0 0", dmem.dmem_req, StallM, obs);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    set_m(1, 1, 0, SZ_NONE, SZ_BYTE, 1, 32'h301, 32'h0, 5'd9);
    dmem.dmem_ready = 1'b1; dmem.dmem_rdata = 32'h0000_8000;
    q.push_back(sb_t'{mk(1, 1, 0, 32'hFFFFFF80, 32'h301, 5'd9, 0, 0), M_ALL});
    #1;
    total++;
    if ({dmem.dmem_req, StallM, dmem.dmem_be} !== {1'b1, 1'b0, 4'b0010}) begin
      bad++; $display("FAIL rst_next_bus: got req=%b stall=%b be=%b want 1 0 0010", dmem.dmem_req, StallM, dmem.dmem_be);
    end
    @(posedge clk); #1;
    nop(); dmem.dmem_ready = 1'b0;
    e = q.pop_front(); total++;
    if ((obs & e.m) !== (e.v & e.m)) begin bad++; $display("FAIL rst_next_w: got %h want %h", obs & e.m, e.v & e.m); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] sz, a;
    logic sg;
    logic [31:0] d;
    for (int k = 0; k < 16; k++) begin
      sz = 2'($urandom_range(1, 3));
      a  = 2'($urandom_range(0, 3));
      a  = sz == SZ_WORD ? 2'b00 : sz == SZ_HALF ? {a[1], 1'b0} : a;
      sg = 1'($urandom);
      d  = $urandom;
      @(negedge clk);
      set_m(1, 1, 0, SZ_NONE, sz, sg, 32'h400 | {30'h0, a}, 32'h0, 5'(k));
      dmem.dmem_ready = 1'b1; dmem.dmem_rdata = d;
      q.push_back(sb_t'{mk(1, 1, 0, model_load(d, a, sz, sg), 32'h400 | {30'h0, a}, 5'(k), 0, 0), M_ALL});
      @(posedge clk); #1;
      e = q.pop_front(); total++;
      if ((obs & e.m) !== (e.v & e.m)) begin bad++; $display("FAIL b2b[%0d]: got %h want %h", k, obs & e.m, e.v & e.m); end
    end
    nop(); dmem.dmem_ready = 1'b0;
  endtask

  initial begin
    nop();
    dmem.dmem_ready = 1'b0;
    dmem.dmem_rdata = 32'h0;
    test_reset();
    test_zero_wait_load();
    test_wait_store();
    test_half_loads();
    test_timeout();
    test_align();
    test_alu_pass();
    test_reset_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
